// File: rtl/mem_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the byte-serial memory responder.
// Size codes use word_size[1:0]; word_size[2] selects zero-extension for loads.
package mem_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam int         ZEXT_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE
  } state_t;

  function automatic logic io_addr(input logic [31:0] a);
    return a[17:16] == 2'b11;
  endfunction

  // Index of the final byte of an access: 0, 1 or 3.
  function automatic logic [1:0] last_byte(input logic [2:0] sz);
    case (sz[1:0])
      SZ_BYTE:          return 2'd0;
      SZ_HALF:          return 2'd1;
      SZ_WORD, 2'd3:    return 2'd3;
      default:          return 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [2:0] sz);
    logic sgn;
    case (sz[1:0])
      SZ_BYTE: begin
        sgn = raw[7] & ~sz[ZEXT_BIT];
        return {{24{sgn}}, raw[7:0]};
      end
      SZ_HALF: begin
        sgn = raw[15] & ~sz[ZEXT_BIT];
        return {{16{sgn}}, raw[15:0]};
      end
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Serialises one load or store request at a time into byte accesses on the RAM/IO port
// and returns the extended load value or a store acknowledge as a one-cycle pulse.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear_up,
  input  logic        lsb_visit_mem,
  input  logic        work_type,
  input  logic [2:0]  word_size,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic        data_out_ready,
  output logic [31:0] data_out,
  output logic        mem_busy,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_t      r_state, w_state_next;
  logic [2:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_st_data;
  logic [31:0] r_ld_data;
  logic [1:0]  r_ptr;
  logic [1:0]  r_last;
  logic        r_reread;
  logic        r_data_out_ready;
  logic [31:0] r_data_out;
  logic        r_busy;
  logic [31:0] r_mem_a;
  logic [7:0]  r_mem_dout;
  logic        r_mem_wr;

  logic        w_accept, w_ld_done, w_st_done;
  logic [1:0]  w_next_ptr;
  logic [31:0] w_next_addr;
  logic [31:0] w_ld_word;
  logic        w_stall_acc, w_stall_next, w_stall_cur;

  assign w_next_ptr   = r_ptr + 2'd1;
  assign w_next_addr  = r_addr + {30'd0, w_next_ptr};
  assign w_stall_acc  = io_addr(addr) && io_buffer_full;
  assign w_stall_next = io_addr(w_next_addr) && io_buffer_full;
  assign w_stall_cur  = io_addr(r_mem_a) && io_buffer_full;

  // Final load byte arrives on mem_din in the same cycle it is folded into the result.
  always_comb begin
    w_ld_word = r_ld_data;
    w_ld_word[{r_ptr, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_ld_done    = 1'b0;
    w_st_done    = 1'b0;
    if (rdy_in) begin
      case (r_state)
        ST_IDLE: begin
          if (lsb_visit_mem && !r_data_out_ready) begin
            w_accept     = 1'b1;
            w_state_next = work_type ? ST_LOAD : ST_STORE;
          end
        end
        ST_LOAD: begin
          if (rob_clear_up) begin
            w_state_next = ST_IDLE;
          end else if (!r_reread && r_ptr == r_last) begin
            w_ld_done    = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
        ST_STORE: begin
          // A store byte only counts as written when mem_wr was high for that cycle.
          if (r_mem_wr && r_ptr == r_last) begin
            w_st_done    = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_size           <= '0;
      r_addr           <= '0;
      r_st_data        <= '0;
      r_ld_data        <= '0;
      r_ptr            <= '0;
      r_last           <= '0;
      r_reread         <= 1'b0;
      r_data_out_ready <= 1'b0;
      r_data_out       <= '0;
      r_busy           <= 1'b0;
      r_mem_a          <= '0;
      r_mem_dout       <= '0;
      r_mem_wr         <= 1'b0;
    end else if (!rdy_in) begin
      r_mem_wr <= 1'b0;
      if (r_state == ST_LOAD) r_reread <= 1'b1;
    end else begin
      r_data_out_ready <= w_ld_done | w_st_done;
      r_busy           <= (w_state_next != ST_IDLE);
      r_reread         <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_size     <= word_size;
            r_addr     <= addr;
            r_st_data  <= data_in;
            r_ld_data  <= '0;
            r_ptr      <= 2'd0;
            r_last     <= last_byte(word_size);
            r_mem_a    <= addr;
            r_mem_dout <= data_in[7:0];
            r_mem_wr   <= !work_type && !w_stall_acc;
          end
        end
        ST_LOAD: begin
          if (!rob_clear_up && !r_reread) begin
            if (w_ld_done) begin
              r_data_out <= load_extend(w_ld_word, r_size);
            end else begin
              r_ld_data <= w_ld_word;
              r_ptr     <= w_next_ptr;
              r_mem_a   <= w_next_addr;
            end
          end
        end
        ST_STORE: begin
          if (w_st_done) begin
            r_mem_wr   <= 1'b0;
            r_data_out <= '0;
          end else if (r_mem_wr) begin
            r_ptr      <= w_next_ptr;
            r_mem_a    <= w_next_addr;
            r_mem_dout <= r_st_data[{w_next_ptr, 3'b000} +: 8];
            r_mem_wr   <= !w_stall_next;
          end else begin
            r_mem_wr <= !w_stall_cur;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out_ready = r_data_out_ready;
  assign data_out       = r_data_out;
  assign mem_busy       = r_busy;
  assign mem_a          = r_mem_a;
  assign mem_dout       = r_mem_dout;
  assign mem_wr         = r_mem_wr;

endmodule
